usb_flash_upload_sequencer: RTL and testbench

//  DFU UPLOAD read sequencer between the DFU control endpoint and the SPI flash bridge.
//  On start, requests one block from the bridge (page address + rd_request).

---
 rtl/usb_flash_upload_sequencer.sv | 161 ++++++++++++++++
 tb/tb_usb_flash_upload_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/usb_flash_upload_sequencer.sv
// rtl/usb_flash_upload_sequencer.sv - DFU UPLOAD read sequencer: flash bridge -> FIFO -> USB IN
// Optional pop-side byte checksum enabled by defining USB_UPLOAD_CHECKSUM_EN.
module usb_flash_upload_sequencer #(
    parameter int DEPTH  = 8,
    parameter int LENGTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] blk_num,
    output logic [15:0] flash_addr,
    input  logic        flash_busy,
    output logic        rd_request,
    output logic        rd_data_free,
    input  logic        rd_data_put,
    input  logic [7:0]  rd_data,
    output logic        in_data_avail,
    input  logic        in_data_get,
    output logic [7:0]  in_data,
    output logic        active,
    output logic        done,
    output logic [7:0]  checksum
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [15:0]   LEN      = 16'(LENGTH);
    localparam logic [15:0]   LEN_LAST = 16'(LENGTH - 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FETCH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [15:0]   rx_cnt;
    logic [15:0]   tx_cnt;
    logic [15:0]   addr_q;
    logic          done_q;

    logic start_ok;
    logic push;
    logic pop;
    logic last_put;
    logic last_pop;

    // Abort outranks everything, so it masks the FIFO strobes as well as start.
    assign start_ok = (state == S_IDLE) && start && !abort;
    assign push     = rd_data_put && (state == S_FETCH) && (fifo_cnt < FULL) && !abort;
    assign pop      = in_data_get && (fifo_cnt != '0) && !abort;
    assign last_put = push && (rx_cnt == LEN_LAST);
    assign last_pop = pop && (state == S_DRAIN) && (tx_cnt == LEN_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Leaving FETCH on the last put itself drops rd_request the cycle after that byte lands.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start)       state_nxt = S_WAIT;
                S_WAIT:  if (!flash_busy) state_nxt = S_FETCH;
                S_FETCH: if (last_put)    state_nxt = S_DRAIN;
                S_DRAIN: if (last_pop)    state_nxt = S_IDLE;
                default:                  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_request   = (state == S_FETCH);
        active       = (state != S_IDLE);
        rd_data_free = (state == S_FETCH) && (rx_cnt < LEN) && (fifo_cnt < FULL);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_pop;
            if (abort) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
            end else if (start_ok) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                fifo_cnt <= '0;
                rx_cnt   <= '0;
                tx_cnt   <= '0;
                addr_q   <= blk_num;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    rx_cnt <= rx_cnt + 16'd1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    tx_cnt <= tx_cnt + 16'd1;
                end
                case ({push, pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                    2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
            end
        end
    end

    assign flash_addr    = addr_q;
    assign in_data_avail = (fifo_cnt != '0);
    assign in_data       = mem[rd_ptr];
    assign done          = done_q;

`ifdef USB_UPLOAD_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || abort || start_ok) begin
            sum_q <= 8'h00;
        end else if (pop) begin
            sum_q <= sum_q + mem[rd_ptr];
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_usb_flash_upload_sequencer.sv
// tb/tb_usb_flash_upload_sequencer.sv - randomized bench with queue-based upload model
module tb_usb_flash_upload_sequencer;

    localparam int DEPTH  = 8;
    localparam int LENGTH = 64;
`ifdef USB_UPLOAD_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] blk_num = 16'h0;
    logic        flash_busy = 1'b0;
    logic        rd_data_put = 1'b0;
    logic [7:0]  rd_data = 8'h0;
    logic        in_data_get = 1'b0;
    logic [15:0] flash_addr;
    logic        rd_request;
    logic        rd_data_free;
    logic        in_data_avail;
    logic [7:0]  in_data;
    logic        active;
    logic        done;
    logic [7:0]  checksum;

    usb_flash_upload_sequencer #(.DEPTH(DEPTH), .LENGTH(LENGTH)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .blk_num(blk_num),
        .flash_addr(flash_addr), .flash_busy(flash_busy), .rd_request(rd_request),
        .rd_data_free(rd_data_free), .rd_data_put(rd_data_put), .rd_data(rd_data),
        .in_data_avail(in_data_avail), .in_data_get(in_data_get), .in_data(in_data),
        .active(active), .done(done), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_done;
    int bridge_cnt;
    int put_pct;
    bit last_put;
    bit seq_data;

    // Model: a job either waits for the bridge, is still owed bytes, or is only emptying the queue.
    bit          m_job, m_go, m_done;
    int          m_rx, m_tx;
    logic [15:0] m_addr;
    logic [7:0]  m_sum;
    logic [7:0]  m_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_job = 0; m_go = 0; m_done = 0; m_rx = 0; m_tx = 0;
        m_addr = 16'h0; m_sum = 8'h0; m_q.delete();
    endtask

    task automatic model_update(input bit st, input bit ab, input bit bz, input bit pt,
                                input logic [7:0] dt, input bit gt, input logic [15:0] blk);
        bit old_job, old_go, can_push, do_pop;
        old_job = m_job;
        old_go  = m_go;
        m_done  = 0;
        if (ab) begin
            m_job = 0; m_go = 0; m_sum = 8'h0; m_q.delete();
        end else begin
            can_push = pt && m_job && m_go && (m_rx < LENGTH) && (m_q.size() < DEPTH);
            do_pop   = gt && (m_q.size() > 0);
            if (do_pop) begin
                m_sum = m_sum + m_q[0];
                void'(m_q.pop_front());
                m_tx++;
                if (m_tx == LENGTH) begin
                    m_done = 1; m_job = 0; m_go = 0;
                end
            end
            if (can_push) begin
                m_q.push_back(dt);
                m_rx++;
            end
            if (!old_job && st) begin
                m_job = 1; m_go = 0; m_rx = 0; m_tx = 0;
                m_addr = blk; m_sum = 8'h0; m_q.delete();
            end else if (old_job && !old_go && !bz) begin
                m_go = 1;
            end
        end
    endtask

    task automatic compare();
        bit e_fetch;
        e_fetch = m_job && m_go && (m_rx < LENGTH);
        chk("active", active, m_job);
        chk("rd_request", rd_request, e_fetch);
        chk("rd_data_free", rd_data_free, e_fetch && (m_q.size() < DEPTH));
        chk("in_data_avail", in_data_avail, m_q.size() != 0);
        if (m_q.size() != 0) chk("in_data", in_data, m_q[0]);
        chk("done", done, m_done);
        chk("flash_addr", flash_addr, m_addr);
        chk("checksum", checksum, CK_EN ? m_sum : 8'h00);
        if (done === 1'b1) n_done++;
    endtask

    task automatic step(input bit st, input bit ab, input bit gt, input bit bz, input bit fp);
        bit pt;
        logic [7:0] dt;
        @(negedge clk);
        compare();
        reset = 1'b0;
        pt = fp || (rd_data_free && !last_put && ($urandom_range(99) < put_pct));
        dt = seq_data ? 8'(bridge_cnt + 1) : 8'($urandom);
        start = st; abort = ab; in_data_get = gt; flash_busy = bz;
        rd_data_put = pt; rd_data = dt;
        model_update(st, ab, bz, pt, dt, gt, blk_num);
        last_put = pt;
        if (pt) bridge_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; start = 0; abort = 0; rd_data_put = 0; in_data_get = 0; flash_busy = 0;
        last_put = 0;
        @(negedge clk);
        model_reset();
        chk("rst_rd_request", rd_request, 0);
        chk("rst_rd_data_free", rd_data_free, 0);
        chk("rst_in_data_avail", in_data_avail, 0);
        chk("rst_done", done, 0);
        chk("rst_active", active, 0);
        chk("rst_checksum", checksum, 0);
        chk("rst_flash_addr", flash_addr, 0);
    endtask

    task automatic run_job(input logic [15:0] blk, input int get_pct, input int ppct, input int busy_n,
                           input int abort_at, input int hold_get, input bit seqd);
        int i, rq_first;
        bit ab, gt;
        i = 0; rq_first = -1;
        bridge_cnt = 0; put_pct = ppct; seq_data = seqd; n_done = 0; blk_num = blk;
        step(1, 0, 0, busy_n > 0, 0);
        while (m_job && i < 3000) begin
            ab = (abort_at >= 0) && (bridge_cnt == abort_at);
            gt = (i >= hold_get) && ($urandom_range(99) < get_pct);
            step(0, ab, gt, i < busy_n - 1, 0);
            if (rq_first < 0 && rd_request === 1'b1) rq_first = i;
            if (hold_get > 0 && i == hold_get - 1) begin
                chk("bp_puts", bridge_cnt, DEPTH);
                chk("bp_free", rd_data_free, 0);
                chk("bp_avail", in_data_avail, 1);
            end
            i++;
        end
        if (i >= 3000) begin
            tests++; fails++;
            $display("FAIL job_timeout: actual %0d cycles, expected completion", i);
        end
        if (abort_at >= 0) begin
            step(0, 0, 0, 0, 0);
            chk("abort_avail", in_data_avail, 0);
            chk("abort_rq", rd_request, 0);
            chk("abort_active", active, 0);
            step(0, 0, 0, 0, 1);
            step(0, 0, 1, 0, 0);
            chk("stray_avail", in_data_avail, 0);
            chk("abort_no_done", n_done, 0);
        end else begin
            step(0, 0, 1, 0, 0);
            chk("done_seen", done, 1);
            chk("idle_at_done", active, 0);
            if (seqd) chk("checksum_lit", checksum, CK_EN ? 8'h20 : 8'h00);
            step(0, 0, 1, 0, 0);
            chk("done_pulses", n_done, 1);
            chk("put_count", bridge_cnt, LENGTH);
            chk("flash_addr_lit", flash_addr, blk);
            // rd_request rises two cycles after the last busy-high cycle (one cycle into the job if never busy).
            chk("rq_latency", rq_first, (busy_n == 0) ? 1 : busy_n);
        end
    endtask

    initial begin
        put_pct = 100; seq_data = 0; last_put = 0; bridge_cnt = 0; n_done = 0;
        do_reset();
        run_job(16'h0003, 100, 100, 0, -1, 0, 1);
        run_job(16'h0010, 100, 100, 0, -1, 40, 0);
        run_job(16'h1234, 100, 100, 20, -1, 0, 0);
        run_job(16'h0042, 100, 100, 0, 30, 0, 0);
        run_job(16'h0043, 100, 100, 0, -1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            run_job(16'($urandom), $urandom_range(20, 100), $urandom_range(20, 100),
                    $urandom_range(0, 5), -1, 0, k[0]);
        end
        run_job(16'h0077, 60, 80, 0, $urandom_range(1, 60), 0, 0);
        blk_num = 16'hBEEF; bridge_cnt = 0; put_pct = 100;
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) step(0, 0, k[0], 0, 0);
        do_reset();
        run_job(16'h0005, 50, 70, 2, -1, 0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
